// File: rtl/test_counter.sv
// Free-running modulo-(MAX+1) counter with a registered output y.
// Define TEST_COUNTER_GRAY_EN to register y as the Gray code of the count.
module test_counter #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1,
    parameter int MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [WIDTH-1:0] y
);

    // One spare bit so count + STEP cannot overflow before the wrap compare.
    localparam logic [WIDTH:0] STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MAX_W   = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] MOD_W   = (WIDTH+1)'(MAX + 1);
    localparam logic [WIDTH:0] LIMIT_W = (WIDTH+1)'(MAX - STEP);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("test_counter: WIDTH must be in 1..16");
    end
    if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_bad_max
        $error("test_counter: MAX must be in 1..2**WIDTH-1");
    end
    if (STEP < 1 || STEP > MAX) begin : g_bad_step
        $error("test_counter: STEP must be in 1..MAX");
    end

    logic [WIDTH:0]   count_reg;
    logic [WIDTH:0]   count_next;
    logic [WIDTH:0]   sum_next;
    logic [WIDTH-1:0] y_next;

    always_comb begin
        sum_next = count_reg + STEP_W;
        if (count_reg <= LIMIT_W) begin
            count_next = sum_next;
        end else begin
            count_next = sum_next - MOD_W;
        end
    end

`ifdef TEST_COUNTER_GRAY_EN
    if (STEP != 1 || MAX != (1 << WIDTH) - 1) begin : g_bad_gray
        $error("test_counter: Gray mode requires STEP=1 and MAX=2**WIDTH-1");
    end

    // count_next[WIDTH] is always 0, so the top Gray bit equals the top binary bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray
        assign y_next[gi] = count_next[gi] ^ count_next[gi+1];
    end
`else
    assign y_next = count_next[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
            y         <= '0;
        end else begin
            count_reg <= count_next;
            y         <= y_next;
        end
    end

    // The compare above relies on count never leaving 0..MAX.
    logic unused_max;
    assign unused_max = ^MAX_W;

endmodule

// File: tb/tb_test_counter.sv
// Directed bench for test_counter: reset hold, wrap, async mid-count reset,
// and (binary build) a STEP=3/MAX=9 instance; Gray build checks one-bit steps.
module tb_test_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] y;

    always #5 clk = ~clk;

    test_counter dut (
        .clk    (clk),
        .resetn (resetn),
        .y      (y)
    );

`ifndef TEST_COUNTER_GRAY_EN
    logic [3:0] y_s3;
    test_counter #(.WIDTH(4), .STEP(3), .MAX(9)) dut_s3 (
        .clk    (clk),
        .resetn (resetn),
        .y      (y_s3)
    );
    logic [3:0] s3_seq [10] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd0};
`endif

    int total = 0;
    int bad   = 0;

    function automatic logic [3:0] enc(input logic [3:0] b);
`ifdef TEST_COUNTER_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) begin
            $display("ok   %-12s observed=%0h expected=%0h", tag, obs, expv);
        end else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    logic [3:0] b;
    logic [3:0] prev;
    int         k;

    initial begin
        resetn = 1'b0;
        #1;
        check("reset_async", 16'(y), 16'h0);

        repeat (10) begin
            @(negedge clk);
            check("reset_hold", 16'(y), 16'h0);
`ifndef TEST_COUNTER_GRAY_EN
            check("s3_reset", 16'(y_s3), 16'h0);
`endif
        end

        resetn = 1'b1;
        b    = 4'd0;
        prev = enc(4'd0);
        k    = 0;
        // 23 edges: wraps 15->0 after the 16th, then stops at 7 for the mid-cycle reset.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            b = b + 4'd1;
            check("count", 16'(y), 16'(enc(b)));
`ifdef TEST_COUNTER_GRAY_EN
            check("gray_hamming", 16'($countones(prev ^ y)), 16'd1);
            prev = y;
`else
            check("s3_count", 16'(y_s3), 16'(s3_seq[k]));
            k = (k + 1) % 10;
`endif
        end

        check("pre_reset", 16'(y), 16'(enc(4'd7)));
        #2;
        resetn = 1'b0;
        #1;
        check("mid_reset", 16'(y), 16'h0);
`ifndef TEST_COUNTER_GRAY_EN
        check("s3_mid_reset", 16'(y_s3), 16'h0);
`endif
        @(negedge clk);
        check("mid_hold", 16'(y), 16'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("restart", 16'(y), 16'(enc(4'd1)));
`ifndef TEST_COUNTER_GRAY_EN
        check("s3_restart", 16'(y_s3), 16'd3);
`endif
        @(negedge clk);
        check("restart2", 16'(y), 16'(enc(4'd2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
